// File: rtl/cmac_accumulator.sv
// rtl/cmac_accumulator.sv - complex product accumulator with valid/ready handshake (optional CMAC_SAT_EN)
module cmac_accumulator #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 24,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_real,
    input  logic [IN_W-1:0]  in_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_real,
    output logic [ACC_W-1:0] out_imag,
    output logic             out_sat
);

    localparam int                CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [0:0]        ST_EMPTY = 1'b0;
    localparam logic [0:0]        ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_real_q, acc_real_d;
    logic [ACC_W-1:0] acc_imag_q, acc_imag_d;
    logic [ACC_W-1:0] res_real_q, res_real_d;
    logic [ACC_W-1:0] res_imag_q, res_imag_d;

    logic             first_beat;
    logic             last_beat;
    logic             accept;
    logic             final_accept;
    logic [ACC_W-1:0] ext_real, ext_imag;
    logic [ACC_W-1:0] base_real, base_imag;
    logic [ACC_W-1:0] sum_real, sum_imag;

    assign first_beat   = (cnt_q == '0);
    assign last_beat    = (cnt_q == CNT_LAST);
    assign out_valid    = (state_q == ST_FULL);
    // Only the final beat can stall: it needs the output register to be free
    // (or freed on this same edge).
    assign in_ready     = !(last_beat && out_valid && !out_ready);
    assign accept       = in_valid && in_ready;
    assign final_accept = accept && last_beat;

    assign ext_real  = ACC_W'($signed(in_real));
    assign ext_imag  = ACC_W'($signed(in_imag));
    // First beat of a vector overwrites the accumulator instead of adding to it.
    assign base_real = first_beat ? '0 : acc_real_q;
    assign base_imag = first_beat ? '0 : acc_imag_q;

`ifdef CMAC_SAT_EN
    logic ovf_real, ovf_imag;
    logic sticky_q, sticky_d;
    logic sat_q, sat_d;

    // Returns {overflow, clamped sum}; overflow only when both operands share
    // a sign and the wrapped result does not.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        logic             ovf;
        s   = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        if (ovf) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return {ovf, s};
    endfunction

    assign {ovf_real, sum_real} = sat_add(base_real, ext_real);
    assign {ovf_imag, sum_imag} = sat_add(base_imag, ext_imag);
    assign out_sat              = sat_q;

    // Sticky clamp flag restarts with each vector and travels with its result.
    always_comb begin
        sticky_d = sticky_q;
        sat_d    = sat_q;
        if (accept) begin
            sticky_d = (first_beat ? 1'b0 : sticky_q) | ovf_real | ovf_imag;
            if (last_beat) begin
                sat_d = sticky_d;
            end
        end
    end

    // Saturation state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            sat_q    <= sat_d;
        end
    end
`else
    assign sum_real = base_real + ext_real;
    assign sum_imag = base_imag + ext_imag;
    assign out_sat  = 1'b0;
`endif

    assign out_real = res_real_q;
    assign out_imag = res_imag_q;

    // Beat counter, accumulator, output register and EMPTY/FULL state.
    always_comb begin
        cnt_d      = cnt_q;
        acc_real_d = acc_real_q;
        acc_imag_d = acc_imag_q;
        res_real_d = res_real_q;
        res_imag_d = res_imag_q;
        state_d    = state_q;
        if (accept) begin
            cnt_d      = last_beat ? '0 : cnt_q + CNT_W'(1);
            acc_real_d = sum_real;
            acc_imag_d = sum_imag;
        end
        if (final_accept) begin
            res_real_d = sum_real;
            res_imag_d = sum_imag;
            state_d    = ST_FULL;
        end else if (out_valid && out_ready) begin
            state_d    = ST_EMPTY;
        end
    end

    // Datapath and control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            cnt_q      <= '0;
            acc_real_q <= '0;
            acc_imag_q <= '0;
            res_real_q <= '0;
            res_imag_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_real_q <= acc_real_d;
            acc_imag_q <= acc_imag_d;
            res_real_q <= res_real_d;
            res_imag_q <= res_imag_d;
        end
    end

endmodule

// File: tb/tb_cmac_accumulator.sv
// tb/tb_cmac_accumulator.sv - directed bench for cmac_accumulator
module tb_cmac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_real, in_imag;

    logic        d_in_ready, d_valid, d_sat;
    logic [23:0] d_real, d_imag;
    logic        o_in_ready, o_valid, o_sat;
    logic [16:0] o_real, o_imag;
    logic        l_in_ready, l_valid, l_sat;
    logic [23:0] l_real, l_imag;

    int n_cmp  = 0;
    int n_bad  = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    cmac_accumulator #(.IN_W(16), .ACC_W(24), .LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_real(in_real), .in_imag(in_imag), .out_valid(d_valid), .out_ready(out_ready),
        .out_real(d_real), .out_imag(d_imag), .out_sat(d_sat)
    );

    cmac_accumulator #(.IN_W(16), .ACC_W(17), .LEN(4)) u_ovf (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready),
        .in_real(in_real), .in_imag(in_imag), .out_valid(o_valid), .out_ready(out_ready),
        .out_real(o_real), .out_imag(o_imag), .out_sat(o_sat)
    );

    cmac_accumulator #(.IN_W(16), .ACC_W(24), .LEN(1)) u_len1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_real(in_real), .in_imag(in_imag), .out_valid(l_valid), .out_ready(out_ready),
        .out_real(l_real), .out_imag(l_imag), .out_sat(l_sat)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until u_dut takes it; returns 1 ns after the accept edge.
    task automatic beat(input int re, input int im);
        int   tries;
        logic ok;
        in_valid = 1'b1;
        in_real  = 16'(re);
        in_imag  = 16'(im);
        tries    = 0;
        do begin
            #1;
            ok = d_in_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 20);
        if (!ok) check("accept_timeout", tries, 0);
        in_valid = 1'b0;
    endtask

    task automatic vec4(input int re, input int im);
        repeat (4) beat(re, im);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps[3];
        gaps = '{0, 3, 2};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_real = '0; in_imag = '0;
        repeat (3) tick();
        check("rst_valid", d_valid, 0);
        check("rst_real", d_real, 0);
        check("rst_imag", d_imag, 0);
        check("rst_sat", d_sat, 0);
        check("rst_ready", d_in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Back-to-back vector, LEN=1 instance reports every beat
        beat(1, 2);
        check("len1_valid", l_valid, 1);
        check("len1_real", int'($signed(l_real)), 1);
        check("len1_imag", int'($signed(l_imag)), 2);
        check("t1_early_valid", d_valid, 0);
        beat(3, 4);
        check("len1_real2", int'($signed(l_real)), 3);
        beat(5, 6);
        beat(7, 8);
        check("t1_valid", d_valid, 1);
        check("t1_real", int'($signed(d_real)), 16);
        check("t1_imag", int'($signed(d_imag)), 20);
        check("t1_no_stall", stalls, 0);
        tick();
        check("t1_pulse", d_valid, 0);

        // Negative values
        vec4(-100, 50);
        check("t2_real", int'($signed(d_real)), -400);
        check("t2_real_raw", int'(d_real), 32'h00FF_FE70);
        check("t2_imag", int'($signed(d_imag)), 200);
        tick();

        // Backpressure
        out_ready = 1'b0;
        vec4(1, 1);
        check("t3_a_valid", d_valid, 1);
        check("t3_a_real", int'($signed(d_real)), 4);
        repeat (3) beat(2, 2);
        check("t3_b_no_stall", stalls, 0);
        in_valid = 1'b1; in_real = 16'd2; in_imag = 16'd2;
        #1;
        check("t3_stall", d_in_ready, 0);
        tick();
        tick();
        check("t3_stall_hold", d_in_ready, 0);
        check("t3_hold_valid", d_valid, 1);
        check("t3_hold_real", int'($signed(d_real)), 4);
        check("t3_hold_imag", int'($signed(d_imag)), 4);
        out_ready = 1'b1;
        #1;
        check("t3_ready_comb", d_in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t3_b_valid", d_valid, 1);
        check("t3_b_real", int'($signed(d_real)), 8);
        check("t3_b_imag", int'($signed(d_imag)), 8);
        tick();
        check("t3_drain", d_valid, 0);

        // Overflow on the 17-bit instance
        vec4(32767, -32768);
        check("t4_wide_real", int'($signed(d_real)), 131068);
        check("t4_wide_imag", int'($signed(d_imag)), -131072);
        check("t4_valid", o_valid, 1);
`ifdef CMAC_SAT_EN
        check("t4_real", int'($signed(o_real)), 65535);
        check("t4_imag", int'($signed(o_imag)), -65536);
        check("t4_sat", o_sat, 1);
`else
        check("t4_real", int'($signed(o_real)), -4);
        check("t4_imag", int'($signed(o_imag)), 0);
        check("t4_sat", o_sat, 0);
`endif
        vec4(1, 1);
        check("t4_next_real", int'($signed(o_real)), 4);
        check("t4_next_sat", o_sat, 0);

        // Reset mid-vector
        beat(10, 10);
        beat(10, 10);
        rst_n = 1'b0;
        repeat (3) tick();
        check("t5_valid", d_valid, 0);
        check("t5_real", d_real, 0);
        check("t5_imag", d_imag, 0);
        check("t5_ovf_real", o_real, 0);
        rst_n = 1'b1;
        tick();
        vec4(1, 0);
        check("t5_after_valid", d_valid, 1);
        check("t5_after_real", int'($signed(d_real)), 4);
        check("t5_after_imag", int'($signed(d_imag)), 0);

        // Bubbles between beats
        for (int i = 0; i < 4; i++) begin
            beat(i + 1, i + 1);
            if (i < 3) begin
                for (int k = 0; k < gaps[i]; k++) begin
                    tick();
                    check("t6_idle_valid", d_valid, 0);
                end
            end
        end
        check("t6_valid", d_valid, 1);
        check("t6_real", int'($signed(d_real)), 10);
        check("t6_imag", int'($signed(d_imag)), 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
